data_buffer_arbiter: RTL and testbench

- Owns access sequencing for the shared 64-byte endpoint data buffer.
- Grants the buffer to one side at a time: the AHB slave side (host fills TX data or drains RX data) or the USB side (protocol engine sends TX data or stores RX data).
- Generates the buffer write/read strobes, the write and read pointers, and the occupancy count.
- Flags overflow, underflow and wrong-phase access.

---
 rtl/data_buffer_arbiter_pkg.sv | 16 +
 rtl/data_buffer_arbiter_ptr.sv | 28 ++
 rtl/data_buffer_arbiter.sv | 155 +++++++++++++++
 tb/tb_data_buffer_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/data_buffer_arbiter_pkg.sv
// Shared constants and state encoding for the endpoint data buffer arbiter.
package data_buffer_arbiter_pkg;

   localparam int unsigned DEPTH  = 64;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned OCC_W  = ADDR_W + 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      AHB_FILL  = 3'd1,
      USB_SEND  = 3'd2,
      USB_RECV  = 3'd3,
      AHB_DRAIN = 3'd4
   } arb_state_t;

endpackage

// File: rtl/data_buffer_arbiter_ptr.sv
// Modulo-depth buffer pointer with increment enable and synchronous clear.
module buffer_ptr_counter
   import data_buffer_arbiter_pkg::*;
#(
   parameter int unsigned PTR_DEPTH = DEPTH,
   parameter int unsigned PTR_W     = ADDR_W
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clr,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   // pointer register, wraps from PTR_DEPTH-1 back to zero
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ptr <= {PTR_W{1'b0}};
      end else if (clr) begin
         ptr <= {PTR_W{1'b0}};
      end else if (inc) begin
         ptr <= (ptr == PTR_W'(PTR_DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: rtl/data_buffer_arbiter.sv
// Sequences AHB and USB access to the shared endpoint buffer and tracks
// pointers, occupancy and access errors.
module data_buffer_arbiter
   import data_buffer_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clr,
   input  logic              ahb_store,
   input  logic              ahb_get,
   input  logic              usb_store,
   input  logic              usb_get,
   input  logic              rx_done,
   output logic              buf_wen,
   output logic              buf_ren,
   output logic [ADDR_W-1:0] write_ptr,
   output logic [ADDR_W-1:0] read_ptr,
   output logic [OCC_W-1:0]  buffer_occupancy,
   output logic              usb_owns,
   output logic              overflow_err,
   output logic              underflow_err,
   output logic              conflict_err
);

   arb_state_t       state_r, next_state_s;
   logic [OCC_W-1:0] occ_r;
   logic             wr_req_s, rd_req_s, conf_s, idle_unf_s;
   logic             full_s, empty_s, last_s, wen_s, ren_s;
   logic             ovf_r, unf_r, conf_r;

   assign full_s  = (occ_r == OCC_W'(DEPTH));
   assign empty_s = (occ_r == OCC_W'(0));
   assign last_s  = (occ_r == OCC_W'(1));

   // next-state and request qualification; clr suppresses everything
   always_comb begin
      next_state_s = state_r;
      wr_req_s     = 1'b0;
      rd_req_s     = 1'b0;
      conf_s       = 1'b0;
      idle_unf_s   = 1'b0;
      if (clr) begin
         next_state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               wr_req_s   = usb_store | ahb_store;
               conf_s     = usb_store & ahb_store;
               idle_unf_s = ahb_get | usb_get;
               if (usb_store) begin
                  next_state_s = USB_RECV;
               end else if (ahb_store) begin
                  next_state_s = AHB_FILL;
               end else begin
                  next_state_s = IDLE;
               end
            end
            AHB_FILL: begin
               rd_req_s = usb_get;
               wr_req_s = ahb_store & ~usb_get;
               conf_s   = usb_store | ahb_get | (usb_get & ahb_store);
               if (usb_get && !empty_s) begin
                  next_state_s = last_s ? IDLE : USB_SEND;
               end else begin
                  next_state_s = AHB_FILL;
               end
            end
            USB_SEND: begin
               rd_req_s = usb_get;
               conf_s   = ahb_store | ahb_get | usb_store;
               if (usb_get && last_s) begin
                  next_state_s = IDLE;
               end else begin
                  next_state_s = USB_SEND;
               end
            end
            USB_RECV: begin
               wr_req_s = usb_store;
               conf_s   = ahb_store | ahb_get | usb_get;
               // occupancy after this edge is zero only if empty and nothing stored now
               if (rx_done) begin
                  next_state_s = (empty_s && !usb_store) ? IDLE : AHB_DRAIN;
               end else begin
                  next_state_s = USB_RECV;
               end
            end
            AHB_DRAIN: begin
               rd_req_s = ahb_get;
               conf_s   = ahb_store | usb_store | usb_get;
               if (ahb_get && last_s) begin
                  next_state_s = IDLE;
               end else begin
                  next_state_s = AHB_DRAIN;
               end
            end
            default: begin
               next_state_s = IDLE;
            end
         endcase
      end
   end

   assign wen_s    = wr_req_s & ~full_s;
   assign ren_s    = rd_req_s & ~empty_s;
   assign buf_wen  = wen_s;
   assign buf_ren  = ren_s;
   assign usb_owns = (state_r == USB_SEND) || (state_r == USB_RECV);

   // state, occupancy and error pulse registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r <= IDLE;
         occ_r   <= OCC_W'(0);
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
         conf_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         if (clr) begin
            occ_r <= OCC_W'(0);
         end else if (wen_s) begin
            occ_r <= occ_r + OCC_W'(1);
         end else if (ren_s) begin
            occ_r <= occ_r - OCC_W'(1);
         end else begin
            occ_r <= occ_r;
         end
         ovf_r  <= wr_req_s & full_s;
         unf_r  <= (rd_req_s & empty_s) | idle_unf_s;
         conf_r <= conf_s;
      end
   end

   assign buffer_occupancy = occ_r;
   assign overflow_err     = ovf_r;
   assign underflow_err    = unf_r;
   assign conflict_err     = conf_r;

   buffer_ptr_counter u_wr_ptr (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (clr),
      .inc   (wen_s),
      .ptr   (write_ptr)
   );

   buffer_ptr_counter u_rd_ptr (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (clr),
      .inc   (ren_s),
      .ptr   (read_ptr)
   );

endmodule

// File: tb/tb_data_buffer_arbiter.sv
// Directed, table-driven bench for data_buffer_arbiter with hand sequences
// for the full boundary, flush and asynchronous reset.
module tb_data_buffer_arbiter;

   logic       clk = 1'b0;
   logic       n_rst, clr, ahb_store, ahb_get, usb_store, usb_get, rx_done;
   logic       buf_wen, buf_ren, usb_owns, overflow_err, underflow_err, conflict_err;
   logic [5:0] write_ptr, read_ptr;
   logic [6:0] buffer_occupancy;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       as, ag, us, ug, rx, cl;
      logic       wen, ren;
      logic [5:0] wp, rp;
      logic [6:0] occ;
      logic       owns, ovf, unf, conf;
   } vec_t;

   vec_t tbl [23];

   data_buffer_arbiter dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .clr              (clr),
      .ahb_store        (ahb_store),
      .ahb_get          (ahb_get),
      .usb_store        (usb_store),
      .usb_get          (usb_get),
      .rx_done          (rx_done),
      .buf_wen          (buf_wen),
      .buf_ren          (buf_ren),
      .write_ptr        (write_ptr),
      .read_ptr         (read_ptr),
      .buffer_occupancy (buffer_occupancy),
      .usb_owns         (usb_owns),
      .overflow_err     (overflow_err),
      .underflow_err    (underflow_err),
      .conflict_err     (conflict_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic as, ag, us, ug, rx, cl);
      @(negedge clk);
      ahb_store = as; ahb_get = ag; usb_store = us;
      usb_get = ug; rx_done = rx; clr = cl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_regs(input string nm, input logic [5:0] wp, rp, input logic [6:0] occ,
                           input logic owns, ovf, unf, conf);
      chk({nm, ".wp"},   write_ptr, wp);
      chk({nm, ".rp"},   read_ptr, rp);
      chk({nm, ".occ"},  buffer_occupancy, occ);
      chk({nm, ".owns"}, usb_owns, owns);
      chk({nm, ".ovf"},  overflow_err, ovf);
      chk({nm, ".unf"},  underflow_err, unf);
      chk({nm, ".conf"}, conflict_err, conf);
   endtask

   initial begin
      // as ag us ug rx cl | wen ren | wp rp occ | owns ovf unf conf
      tbl[0]  = '{1,0,0,0,0,0, 1,0, 6'd1, 6'd0, 7'd1, 0,0,0,0};
      tbl[1]  = '{1,0,0,0,0,0, 1,0, 6'd2, 6'd0, 7'd2, 0,0,0,0};
      tbl[2]  = '{1,0,0,0,0,0, 1,0, 6'd3, 6'd0, 7'd3, 0,0,0,0};
      tbl[3]  = '{1,0,0,0,0,0, 1,0, 6'd4, 6'd0, 7'd4, 0,0,0,0};
      tbl[4]  = '{1,0,0,0,0,0, 1,0, 6'd5, 6'd0, 7'd5, 0,0,0,0};
      tbl[5]  = '{0,0,0,1,0,0, 0,1, 6'd5, 6'd1, 7'd4, 1,0,0,0};
      tbl[6]  = '{0,0,0,1,0,0, 0,1, 6'd5, 6'd2, 7'd3, 1,0,0,0};
      tbl[7]  = '{0,0,0,1,0,0, 0,1, 6'd5, 6'd3, 7'd2, 1,0,0,0};
      tbl[8]  = '{0,0,0,1,0,0, 0,1, 6'd5, 6'd4, 7'd1, 1,0,0,0};
      tbl[9]  = '{0,0,0,1,0,0, 0,1, 6'd5, 6'd5, 7'd0, 0,0,0,0};
      tbl[10] = '{0,0,0,1,0,0, 0,0, 6'd5, 6'd5, 7'd0, 0,0,1,0};
      tbl[11] = '{0,0,1,0,0,0, 1,0, 6'd6, 6'd5, 7'd1, 1,0,0,0};
      tbl[12] = '{0,0,1,0,0,0, 1,0, 6'd7, 6'd5, 7'd2, 1,0,0,0};
      tbl[13] = '{0,0,1,0,0,0, 1,0, 6'd8, 6'd5, 7'd3, 1,0,0,0};
      tbl[14] = '{0,1,0,0,0,0, 0,0, 6'd8, 6'd5, 7'd3, 1,0,0,1};
      tbl[15] = '{0,0,0,0,1,0, 0,0, 6'd8, 6'd5, 7'd3, 0,0,0,0};
      tbl[16] = '{0,1,0,0,0,0, 0,1, 6'd8, 6'd6, 7'd2, 0,0,0,0};
      tbl[17] = '{0,1,0,0,0,0, 0,1, 6'd8, 6'd7, 7'd1, 0,0,0,0};
      tbl[18] = '{0,1,0,0,0,0, 0,1, 6'd8, 6'd8, 7'd0, 0,0,0,0};
      tbl[19] = '{1,0,1,0,0,0, 1,0, 6'd9, 6'd8, 7'd1, 1,0,0,1};
      tbl[20] = '{0,0,1,0,1,0, 1,0, 6'd10, 6'd8, 7'd2, 0,0,0,0};
      tbl[21] = '{0,1,0,0,0,0, 0,1, 6'd10, 6'd9, 7'd1, 0,0,0,0};
      tbl[22] = '{0,1,0,0,0,0, 0,1, 6'd10, 6'd10, 7'd0, 0,0,0,0};

      n_rst = 1'b0; clr = 1'b0; ahb_store = 1'b0; ahb_get = 1'b0;
      usb_store = 1'b0; usb_get = 1'b0; rx_done = 1'b0;
      #2;
      chk("rst.wen", buf_wen, 1'b0);
      chk("rst.ren", buf_ren, 1'b0);
      chk_regs("rst", 6'd0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      for (int i = 0; i < 23; i++) begin
         set_in(tbl[i].as, tbl[i].ag, tbl[i].us, tbl[i].ug, tbl[i].rx, tbl[i].cl);
         chk($sformatf("v%0d.wen", i), buf_wen, tbl[i].wen);
         chk($sformatf("v%0d.ren", i), buf_ren, tbl[i].ren);
         tick();
         chk_regs($sformatf("v%0d", i), tbl[i].wp, tbl[i].rp, tbl[i].occ,
                  tbl[i].owns, tbl[i].ovf, tbl[i].unf, tbl[i].conf);
      end

      // flush after 10 writes, with a simultaneous usb_get
      for (int i = 0; i < 10; i++) begin
         set_in(1, 0, 0, 0, 0, 0);
         tick();
      end
      chk("fill10.occ", buffer_occupancy, 7'd10);
      chk("fill10.wp", write_ptr, 6'd20);
      set_in(0, 0, 0, 1, 0, 1);
      chk("clr.ren", buf_ren, 1'b0);
      chk("clr.wen", buf_wen, 1'b0);
      tick();
      chk_regs("clr", 6'd0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_in(0, 1, 0, 0, 0, 0);
      tick();
      chk("clr.idle_unf", underflow_err, 1'b1);
      chk("clr.idle_conf", conflict_err, 1'b0);

      // full boundary: 64 stores then a 65th
      for (int i = 0; i < 64; i++) begin
         set_in(1, 0, 0, 0, 0, 0);
         tick();
      end
      chk_regs("full", 6'd0, 6'd0, 7'd64, 1'b0, 1'b0, 1'b0, 1'b0);
      set_in(1, 0, 0, 0, 0, 0);
      chk("ovf.wen", buf_wen, 1'b0);
      tick();
      chk_regs("ovf", 6'd0, 6'd0, 7'd64, 1'b0, 1'b1, 1'b0, 1'b0);
      set_in(0, 0, 0, 0, 0, 0);
      tick();
      chk("ovf.pulse_end", overflow_err, 1'b0);
      set_in(0, 0, 0, 0, 0, 1);
      tick();

      // async reset in USB_SEND with occupancy 7
      for (int i = 0; i < 8; i++) begin
         set_in(1, 0, 0, 0, 0, 0);
         tick();
      end
      set_in(0, 0, 0, 1, 0, 0);
      tick();
      chk_regs("send7", 6'd8, 6'd1, 7'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      set_in(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #3;
      n_rst = 1'b0;
      #1;
      chk_regs("arst", 6'd0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      n_rst = 1'b1;
      set_in(1, 0, 0, 0, 0, 0);
      chk("post.wen", buf_wen, 1'b1);
      tick();
      set_in(1, 0, 0, 0, 0, 0);
      tick();
      chk_regs("post.fill", 6'd2, 6'd0, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      set_in(0, 0, 0, 1, 0, 0);
      chk("post.ren", buf_ren, 1'b1);
      tick();
      chk_regs("post.send", 6'd2, 6'd1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      set_in(0, 0, 0, 1, 0, 0);
      tick();
      chk_regs("post.idle", 6'd2, 6'd2, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_in(0, 0, 0, 0, 0, 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
